// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD seven-segment display block.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  // Entry N is the pattern for decimal digit N.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef enum logic [1:0] {
    IDX_ONES = 2'd0,
    IDX_TENS = 2'd1,
    IDX_HUND = 2'd2
  } digit_idx_t;

  function automatic logic [3:0] digit_nibble(input logic [11:0] bcd, input digit_idx_t idx);
    logic [3:0] nib;
    case (idx)
      IDX_ONES: nib = bcd[3:0];
      IDX_TENS: nib = bcd[7:4];
      IDX_HUND: nib = bcd[11:8];
      default:  nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/bcd_sevenseg_display_if.sv
// Counter-to-display value path plus the display drive lines.
interface bcd_sevenseg_display_if;
  logic [11:0] BCD_IN;
  logic        DONE;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  modport master (output BCD_IN, output DONE, input AN, input SEG);
  modport slave  (input BCD_IN, input DONE, output AN, output SEG);
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational nibble to active-low seven-segment pattern; non-BCD codes show a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (nibble <= 4'd9) begin
      seg = SEG_LUT[nibble];
    end
  end

endmodule

// File: rtl/bcd_sevenseg_display.sv
// Scans a 3-digit BCD value onto a multiplexed common-anode display with
// leading-zero blanking, frame-aligned value capture and blinking while done.
module bcd_sevenseg_display
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_sevenseg_display_if.slave   disp
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST   = FW'(BLINK_FRAMES - 1);

  logic [RW-1:0] refresh_cnt_reg, refresh_cnt_next;
  digit_idx_t    idx_reg, idx_next;
  logic [11:0]   shadow_reg, shadow_next;
  logic          done_q_reg;
  logic          done_flag_reg, done_flag_next;
  logic          blink_reg, blink_next;
  logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;

  logic          refresh_tc;
  logic          frame_end;
  logic          done_rise;
  logic          done_fall;
  logic [3:0]    sel_nibble;
  logic [6:0]    dec_seg;
  logic [3:0]    an_lit;
  logic          blank;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_reg <= '0;
      idx_reg         <= IDX_ONES;
      shadow_reg      <= 12'h000;
      done_q_reg      <= 1'b0;
      done_flag_reg   <= 1'b0;
      blink_reg       <= 1'b0;
      frame_cnt_reg   <= '0;
      an_reg          <= AN_OFF;
      seg_reg         <= SEG_OFF;
    end else begin
      refresh_cnt_reg <= refresh_cnt_next;
      idx_reg         <= idx_next;
      shadow_reg      <= shadow_next;
      done_q_reg      <= disp.DONE;
      done_flag_reg   <= done_flag_next;
      blink_reg       <= blink_next;
      frame_cnt_reg   <= frame_cnt_next;
      an_reg          <= an_next;
      seg_reg         <= seg_next;
    end
  end

  assign refresh_tc = (refresh_cnt_reg == REFRESH_LAST);
  assign frame_end  = refresh_tc && (idx_reg == IDX_HUND);
  assign done_rise  = disp.DONE && !done_q_reg;
  assign done_fall  = !disp.DONE && done_q_reg;

  always_comb begin
    refresh_cnt_next = refresh_tc ? '0 : refresh_cnt_reg + 1'b1;
    idx_next         = idx_reg;
    shadow_next      = shadow_reg;
    done_flag_next   = done_flag_reg;
    blink_next       = blink_reg;
    frame_cnt_next   = frame_cnt_reg;

    if (refresh_tc) begin
      case (idx_reg)
        IDX_ONES: idx_next = IDX_TENS;
        IDX_TENS: idx_next = IDX_HUND;
        default:  idx_next = IDX_ONES;
      endcase
    end

    // Only take a new value between frames so all digits change together.
    if (frame_end && !done_flag_reg) begin
      shadow_next = disp.BCD_IN;
    end

    if (done_rise) begin
      shadow_next    = disp.BCD_IN;
      done_flag_next = 1'b1;
      frame_cnt_next = '0;
      blink_next     = 1'b0;
    end else if (done_fall) begin
      done_flag_next = 1'b0;
      frame_cnt_next = '0;
      blink_next     = 1'b0;
    end else if (done_flag_reg && frame_end) begin
      if (frame_cnt_reg == FRAME_LAST) begin
        frame_cnt_next = '0;
        blink_next     = !blink_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
      end
    end
  end

  assign sel_nibble = digit_nibble(shadow_reg, idx_reg);

  bcd_to_seg u_dec (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_anode
      assign an_lit[gi] = (idx_reg != digit_idx_t'(gi));
    end
  endgenerate
  assign an_lit[3] = 1'b1;

  // An invalid nibble is non-zero, so it never triggers blanking.
  always_comb begin
    blank = 1'b0;
    case (idx_reg)
      IDX_HUND: blank = (shadow_reg[11:8] == 4'h0);
      IDX_TENS: blank = (shadow_reg[11:8] == 4'h0) && (shadow_reg[7:4] == 4'h0);
      default:  blank = 1'b0;
    endcase
  end

  always_comb begin
    an_next  = an_lit;
    seg_next = dec_seg;
    if (blank) begin
      an_next  = AN_OFF;
      seg_next = SEG_OFF;
    end else if (blink_reg) begin
      an_next = AN_OFF;
    end
  end

  assign disp.AN  = an_reg;
  assign disp.SEG = seg_reg;

endmodule

// File: tb/tb_bcd_sevenseg_display.sv
// Bench for bcd_sevenseg_display: cycle-exact scoreboard of AN/SEG with a small
// frame/blink model, plus direct checks of the reset behaviour.
module tb_bcd_sevenseg_display;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 3 * RD;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_sevenseg_display_if disp_if ();

  bcd_sevenseg_display #(
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp_if)
  );

  always #5 clk = ~clk;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [10:0] exp_q[$];

  // Reference model state; k counts clock edges since reset release.
  int          k;
  logic [11:0] m_shadow;
  logic        m_done_q;
  logic        m_flag;
  logic        m_blink;
  int          m_frames;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [10:0] expect_out();
    int         s;
    logic [3:0] h, t, n, an;
    s  = (k / RD) % 3;
    h  = m_shadow[11:8];
    t  = m_shadow[7:4];
    n  = m_shadow[s*4 +: 4];
    if ((s == 2 && h == 4'h0) || (s == 1 && h == 4'h0 && t == 4'h0))
      return {4'b1111, 7'h7F};
    an    = 4'b1111;
    an[s] = 1'b0;
    if (m_blink) an = 4'b1111;
    return {an, seg_of(n)};
  endfunction

  task automatic model_reset();
    k        = 0;
    m_shadow = 12'h000;
    m_done_q = 1'b0;
    m_flag   = 1'b0;
    m_blink  = 1'b0;
    m_frames = 0;
  endtask

  task automatic model_advance();
    logic boundary, rise, fall;
    boundary = ((k % FRAME) == FRAME - 1);
    rise     = disp_if.DONE && !m_done_q;
    fall     = !disp_if.DONE && m_done_q;
    if (boundary && !m_flag) m_shadow = disp_if.BCD_IN;
    if (rise) begin
      m_shadow = disp_if.BCD_IN;
      m_flag   = 1'b1;
      m_frames = 0;
      m_blink  = 1'b0;
    end else if (fall) begin
      m_flag   = 1'b0;
      m_frames = 0;
      m_blink  = 1'b0;
    end else if (m_flag && boundary) begin
      m_frames++;
      if (m_frames == BF) begin
        m_frames = 0;
        m_blink  = !m_blink;
      end
    end
    m_done_q = disp_if.DONE;
    k++;
  endtask

  // Push the expectation for the coming edge, clock once, then score the DUT.
  task automatic step(input string tag);
    logic [10:0] e;
    exp_q.push_back(expect_out());
    model_advance();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val($sformatf("%s@%0d", tag, k), {disp_if.AN, disp_if.SEG}, e);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", err_cnt + 1, chk_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    disp_if.BCD_IN = 12'h000;
    disp_if.DONE   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_val("reset_an", disp_if.AN, 4'b1111);
    check_val("reset_seg", disp_if.SEG, 7'h7F);
    rst = 1'b1;
    model_reset();

    // Scan of 123, also leaves the design mid-frame for the async reset.
    disp_if.BCD_IN = 12'h123;
    run("scan123", 40);

    #3;
    rst = 1'b0;
    #1;
    check_val("async_rst_an", disp_if.AN, 4'b1111);
    check_val("async_rst_seg", disp_if.SEG, 7'h7F);
    @(posedge clk);
    #1;
    check_val("held_rst_an", disp_if.AN, 4'b1111);
    rst = 1'b1;
    model_reset();

    step("after_rst");
    check_val("first_lit", {disp_if.AN, disp_if.SEG}, {4'b1110, 7'h40});
    run("after_rst", 23);

    disp_if.BCD_IN = 12'h007;
    run("blank007", 24);
    disp_if.BCD_IN = 12'h040;
    run("blank040", 24);
    disp_if.BCD_IN = 12'h0A5;
    run("invalid0A5", 24);

    disp_if.BCD_IN = 12'h111;
    run("tear111", 24);
    run("tear111", 5);
    disp_if.BCD_IN = 12'h222;
    run("tear222", 24);

    // Done mid-frame: 256 frozen, blinking, later value ignored.
    disp_if.BCD_IN = 12'h256;
    disp_if.DONE   = 1'b1;
    step("done_rise");
    disp_if.BCD_IN = 12'h999;
    run("blink256", 60);
    disp_if.DONE = 1'b0;
    run("done_fall", 36);

    // Done rising exactly on a frame boundary.
    while ((k % FRAME) != FRAME - 1) step("align");
    disp_if.BCD_IN = 12'h345;
    disp_if.DONE   = 1'b1;
    step("done_edge");
    disp_if.BCD_IN = 12'h000;
    run("blink345", 30);
    disp_if.DONE = 1'b0;
    run("release", 24);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_display.md
Name: bcd_sevenseg_display

Overview:
Consumes the 3-digit packed-BCD count (BCD_IN[11:0]) and DONE flag produced by the counter block. Drives a 4-digit common-anode seven-segment display by time-multiplexed scanning. Leading zeros are blanked and invalid nibbles are shown as a dash. While DONE is high, the final value is frozen and the display blinks.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit (one frame = 3*REFRESH_DIV cycles)
BLINK_FRAMES, 50, frames per blink half-period while done

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
BCD_IN  in  12  {hundreds, tens, ones} packed BCD from counter
DONE  in  1  count-complete level from counter
AN  out  4  digit anodes, active-low; AN[0]=ones, AN[1]=tens, AN[2]=hundreds, AN[3] unused
SEG  out  7  segments, active-low, {g,f,e,d,c,b,a}

Behaviour:
- Reset (rst=0, asynchronous): AN=4'b1111, SEG=7'h7F, refresh counter=0, digit index=0, shadow=12'h000, done_flag=0, blink phase=0, frame counter=0.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. At terminal count, digit index advances 0->1->2->0.
- Registered outputs: AN and SEG load every clk from the current index and shadow, so they lag the index by 1 cycle. AN[3] is always 1.
- Shadow capture (anti-tearing): the shadow loads BCD_IN only at end of frame (refresh terminal count and index==2) and only when done_flag=0. Mid-frame BCD_IN changes are invisible until then.
- DONE rising edge (DONE registered; rise = DONE & ~DONE_q): shadow <= BCD_IN in that cycle, done_flag <= 1, frame counter=0, blink phase=0.
- While done_flag=1:
  - Shadow is held.
  - Frame counter increments at each end of frame. At count BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
  - Blink phase=1 forces AN=4'b1111.
- DONE falling edge: done_flag, blink phase and frame counter clear. Normal capture resumes at the next frame boundary.
- DONE rising while already done cannot occur (level input). A DONE rise coinciding with a frame boundary takes the DONE capture (same value).
- Decode (per digit):
  - 0-9 map to 40,79,24,30,19,12,02,78,00,10 (hex).
  - Nibble >9 maps to 7'h3F (segment g only).
- Leading-zero blanking:
  - Hundreds slot blanked if hundreds==0.
  - Tens slot blanked if hundreds==0 and tens==0.
  - Ones slot never blanked.
  - A blanked slot drives AN=4'b1111 and SEG=7'h7F.
  - An invalid nibble counts as non-zero.
- Reset mid-operation: all state returns to reset values immediately. Scanning restarts at index 0 after release.
- Widths: refresh counter is $clog2(REFRESH_DIV) bits, frame counter is $clog2(BLINK_FRAMES) bits. Both are sized so terminal compares are exact.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - SEG_LUT constants for digits 0-9
  - SEG_DASH=7'h3F
  - SEG_OFF=7'h7F
  - AN_OFF=4'b1111
  - digit index encoding (IDX_ONES=0, IDX_TENS=1, IDX_HUND=2)
- One sub-module, bcd_to_seg: combinational 4-bit nibble to 7-bit active-low pattern. It is instantiated once on the mux-selected nibble.

Test Plan:
(All scenarios use REFRESH_DIV=4, BLINK_FRAMES=2; frame = 12 cycles.)
1. Reset: pull rst low mid-scan, off a clk edge -> AN=1111 and SEG=7F immediately. After release, first lit slot is AN=1110 with SEG=40 ("0" from shadow=000); tens and hundreds slots are dark.
2. Scan: BCD_IN=12'h123 held -> after first frame boundary, repeating AN 1110/SEG 30, 1101/SEG 24, 1011/SEG 79, 4 cycles each. AN[3]=1 throughout.
3. Blanking:
   - BCD_IN=12'h007 -> only the ones slot is lit (SEG 78); the other slots show AN=1111.
   - BCD_IN=12'h040 -> hundreds dark, tens SEG 19, ones SEG 40.
4. Invalid nibble: BCD_IN=12'h0A5 -> tens slot SEG=3F, ones SEG=12, hundreds dark.
5. Tearing: change BCD_IN 12'h111->12'h222 mid-frame -> all three digits keep showing 1 until the frame boundary, then all show 2 together.
6. Done/blink:
   - BCD_IN=12'h256, DONE rises, then BCD_IN=12'h999 -> display holds 256, lit for 2 frames, dark for 2 frames, repeating.
   - DONE falls -> blinking stops and 999 appears after the next frame boundary.
